matrix_window_loader: RTL and testbench
=======================================

# matrix_window_loader

Serial-to-parallel operand loader for the convolution datapath. Accepts matrix elements one byte per handshake in row-major order and packs them into the 200-bit, 5x5-stride operand format used by the convolution unit's `matrix_a` and `matrix_b` inputs. Unused positions are zero-filled. A double-buffered output lets the next matrix load while the previous one waits to be consumed.

## Interface
- `ELEM_W`, 8: element width in bits.
- `MAX_N`, 5: maximum matrix dimension and packing stride; `matrix_out` width = `ELEM_W*MAX_N*MAX_N` (200 at defaults).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: begin a new load; sampled only in IDLE.
- `matrix_size` in 2: 00=2x2, 01=3x3, 10=4x4, 11=5x5; latched on accepted `start`.
- `in_valid` in 1: `in_data` is valid.
- `in_data` in ELEM_W: element value, raw bits (pixel or signed kernel, not interpreted).
- `in_ready` out 1: loader accepts an element this cycle.
- `out_valid` out 1: `matrix_out` / `size_out` hold a complete matrix.
- `out_ready` in 1: consumer takes the output this cycle.
- `matrix_out` out 200: packed matrix; element (r,c) at bits `[(r*MAX_N+c)*ELEM_W +: ELEM_W]`.
- `size_out` out 2: `matrix_size` code belonging to `matrix_out`.
- `busy` out 1: state != IDLE.

## Operation
- States: IDLE, LOAD, PEND.
- IDLE: `in_ready`=0. On `start`=1: latch size (N = code+2), clear the load buffer to all zero, reset row/col counters to 0, and go to LOAD.
- LOAD: `in_ready`=1. On each `in_valid && in_ready`, write `in_data` at index row*5+col. Then col++; if col==N-1, set col=0 and row++.
- Last element (row==N-1, col==N-1) accepted:
  - If the output slot is free (`out_valid`==0 or `out_ready`==1 this cycle), copy the buffer to `matrix_out`, copy size to `size_out`, and go to IDLE.
  - Otherwise go to PEND.
- PEND: `in_ready`=0. When `out_ready`=1, copy the buffer and size into the output register and go to IDLE.
- Output register:
  - `out_valid` sets on a copy.
  - It clears on `out_ready && out_valid` unless a copy occurs in the same cycle; a copy wins and `out_valid` stays 1.
  - Contents are stable while `out_valid && !out_ready`.
- `start` in LOAD or PEND is ignored. `matrix_size` changes after latching are ignored.
- Positions outside the NxN region are always 0 in `matrix_out`.
- `in_data` is not modified in any way (no sign extension, no saturation).

## Timing
- Reset (async, while `rst_n`=0): state IDLE, counters 0, buffer 0, `matrix_out`=0, `size_out`=0, `out_valid`=0, `in_ready`=0, `busy`=0. Reset mid-load discards partial data.
- `start` accepted in cycle t: `busy` and `in_ready` are high from cycle t+1.
- Minimum load time is N*N cycles with `in_valid` held high. Gaps in `in_valid` stall the counters without penalty.
- Last element accepted in cycle k with the slot free: `out_valid`=1 and new `matrix_out` in cycle k+1, `busy`=0 in cycle k+1.
- Back-to-back: `start` is accepted in the first IDLE cycle, so the next load starts one cycle after a copy.
- PEND exit: the copy happens on the `out_ready` cycle; new data is visible the next cycle with `out_valid` continuously 1.

## Test plan
- 3x3 load, bytes 1..9, `out_ready`=1 → indices 0,1,2,5,6,7,10,11,12 = 1..9, all other bytes 0, `size_out`=01, `out_valid` high in the cycle after the 9th handshake.
- 2x2 load with `in_valid` toggled 1,0,1,0,... (bytes 0x80,0x7F,0xFF,0x01) → indices 0,1,5,6 hold those values, no extra or dropped elements, `matrix_out[199:56]` = 0.
- 5x5 load, all 0xFF → `matrix_out` all ones. A following 2x2 load of zeros → `matrix_out` all zero; stale data must be cleared.
- Backpressure: `out_ready`=0, two consecutive 2x2 loads (A then B) → after B's last byte the state is PEND, `in_ready`=0, `matrix_out`=A. Pulse `out_ready` → next cycle `matrix_out`=B, `out_valid` still 1, state IDLE.
- `start` and a `matrix_size` change during LOAD → ignored; the load completes with the originally latched size.
- `rst_n` low after 4 of 9 elements → all outputs 0 immediately (asynchronous). After release, a new 3x3 load completes correctly.

Source files
------------

// File: rtl/matrix_window_loader_if.sv
// Loader handshake/bus bundle.
//   master : operand producer/consumer side (drives start, size, elements, out_ready)
//   slave  : the loader itself
// Signals:
//   start, matrix_size      - begin a load, size code (00=2x2 .. 11=5x5)
//   in_valid/in_data/in_ready - one element per handshake, row-major
//   out_valid/out_ready     - output slot handshake
//   matrix_out, size_out    - packed MAX_N x MAX_N matrix and its size code
//   busy                    - loader not idle
interface matrix_window_loader_if #(
  parameter int ELEM_W = 8,
  parameter int MAX_N  = 5
);
  localparam int MAT_W = ELEM_W * MAX_N * MAX_N;

  logic              start;
  logic [1:0]        matrix_size;
  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [MAT_W-1:0]  matrix_out;
  logic [1:0]        size_out;
  logic              busy;

  modport master (
    output start, matrix_size, in_valid, in_data, out_ready,
    input  in_ready, out_valid, matrix_out, size_out, busy
  );

  modport slave (
    input  start, matrix_size, in_valid, in_data, out_ready,
    output in_ready, out_valid, matrix_out, size_out, busy
  );
endinterface

// File: rtl/matrix_window_loader.sv
// Serial-to-parallel operand loader. Takes NxN elements (N = 2..MAX_N) one per
// handshake in row-major order and packs them at a fixed MAX_N stride into a
// zero-filled MAX_N*MAX_N*ELEM_W word. The load buffer and the output register
// form a double buffer so the next matrix can load while the last one waits.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - matrix_window_loader_if.slave (start/size, element stream, output slot)
module matrix_window_loader #(
  parameter int ELEM_W = 8,
  parameter int MAX_N  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matrix_window_loader_if.slave bus
);
  localparam int NE    = MAX_N * MAX_N;
  localparam int IDX_W = $clog2(NE);
  localparam int CNT_W = $clog2(MAX_N + 1);

  typedef logic [NE-1:0][ELEM_W-1:0] mat_t;
  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q;
  logic [CNT_W-1:0]  row_q, col_q, n_m1;
  logic [IDX_W-1:0]  idx;
  mat_t              ld_buf, buf_d, mat_q;
  logic [1:0]        size_out_q;
  logic              out_valid_q;
  logic              start_acc, accept, last, slot_free, copy;

  assign n_m1      = CNT_W'(size_q) + CNT_W'(1);
  assign start_acc = (state_q == IDLE) && bus.start;
  assign accept    = (state_q == LOAD) && bus.in_valid;
  assign last      = accept && (row_q == n_m1) && (col_q == n_m1);
  assign slot_free = !out_valid_q || bus.out_ready;
  assign idx       = IDX_W'(row_q) * IDX_W'(MAX_N) + IDX_W'(col_q);

  // Next buffer contents; the copy takes this so the last element written in
  // the copy cycle lands in matrix_out.
  always_comb begin
    buf_d = ld_buf;
    if (start_acc) buf_d = '0;
    if (accept)    buf_d[idx] = bus.in_data;
  end

  always_comb begin
    state_d = state_q;
    copy    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) state_d = LOAD;
      LOAD: if (last) begin
        if (slot_free) begin
          copy    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      PEND: if (bus.out_ready) begin
        copy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      size_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ld_buf  <= '0;
    end else begin
      state_q <= state_d;
      ld_buf  <= buf_d;
      if (start_acc) begin
        size_q <= bus.matrix_size;
        row_q  <= '0;
        col_q  <= '0;
      end else if (accept) begin
        if (col_q == n_m1) begin
          col_q <= '0;
          row_q <= row_q + CNT_W'(1);
        end else begin
          col_q <= col_q + CNT_W'(1);
        end
      end
    end
  end

  // Output slot: a copy always wins over a same-cycle consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_q       <= '0;
      size_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (copy) begin
      mat_q       <= buf_d;
      size_out_q  <= size_q;
      out_valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = (state_q == LOAD);
  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.matrix_out = mat_q;
  assign bus.size_out   = size_out_q;
endmodule

// File: tb/tb_matrix_window_loader.sv
module tb_matrix_window_loader;
  localparam int ELEM_W = 8;
  localparam int MAX_N  = 5;
  localparam int MAT_W  = ELEM_W * MAX_N * MAX_N;

  typedef struct {
    logic [1:0]           size;
    bit                   gaps;
    logic [24:0][7:0]     din;
    logic [MAT_W-1:0]     exp_mat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs[5];

  matrix_window_loader_if #(.ELEM_W(ELEM_W), .MAX_N(MAX_N)) bus ();

  matrix_window_loader #(.ELEM_W(ELEM_W), .MAX_N(MAX_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entered just after a negedge; returns just after the negedge that follows
  // the final beat's handshake edge.
  task automatic do_load(input logic [1:0] sz, input logic [24:0][7:0] d, input int nbeats,
                         input bit gaps, input bit inject, input bit ov0_chk);
    bus.start       = 1'b1;
    bus.matrix_size = sz;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", MAT_W'(bus.busy), MAT_W'(1));
    for (int i = 0; i < nbeats; i++) begin
      if (inject && i == 3) begin
        bus.start       = 1'b1;
        bus.matrix_size = 2'b11;
      end
      if (inject && i == 6) bus.start = 1'b0;
      chk("in_ready_load", MAT_W'(bus.in_ready), MAT_W'(1));
      if (ov0_chk && i == nbeats - 1) chk("out_valid_before_last", MAT_W'(bus.out_valid), MAT_W'(0));
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      @(negedge clk);
      if (gaps && i != nbeats - 1) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_done(input string tag, input logic [1:0] sz, input logic [MAT_W-1:0] exp);
    chk({tag, "_out_valid"}, MAT_W'(bus.out_valid), MAT_W'(1));
    chk({tag, "_matrix_out"}, bus.matrix_out, exp);
    chk({tag, "_size_out"}, MAT_W'(bus.size_out), MAT_W'(sz));
    chk({tag, "_busy"}, MAT_W'(bus.busy), MAT_W'(0));
    chk({tag, "_in_ready"}, MAT_W'(bus.in_ready), MAT_W'(0));
  endtask

  initial begin
    logic [24:0][7:0] d;
    logic [MAT_W-1:0] exp_a, exp_b, exp_v1;
    int n;
    checks   = 0;
    failures = 0;

    vecs[0].size = 2'b01; vecs[0].gaps = 1'b0;
    for (int i = 0; i < 25; i++) vecs[0].din[i] = (i < 9) ? 8'(i + 1) : 8'h00;
    vecs[0].exp_mat = 200'h090807_0000_060504_0000_030201;
    vecs[1].size = 2'b00; vecs[1].gaps = 1'b1;
    vecs[1].din = 200'h01FF7F80;
    vecs[1].exp_mat = 200'h01FF_000000_7F80;
    vecs[2].size = 2'b11; vecs[2].gaps = 1'b0;
    vecs[2].din = '1;
    vecs[2].exp_mat = '1;
    vecs[3].size = 2'b00; vecs[3].gaps = 1'b0;
    vecs[3].din = '0;
    vecs[3].exp_mat = '0;
    vecs[4].size = 2'b10; vecs[4].gaps = 1'b0;
    for (int i = 0; i < 25; i++) vecs[4].din[i] = (i < 16) ? 8'(16 + i) : 8'h00;
    vecs[4].exp_mat = 200'h1F1E1D1C_00_1B1A1918_00_17161514_00_13121110;
    exp_v1 = vecs[0].exp_mat;

    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.matrix_size = 2'b00;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", MAT_W'(bus.out_valid), MAT_W'(0));
    chk("rst_matrix_out", bus.matrix_out, '0);
    chk("rst_size_out", MAT_W'(bus.size_out), MAT_W'(0));
    chk("rst_busy", MAT_W'(bus.busy), MAT_W'(0));
    chk("rst_in_ready", MAT_W'(bus.in_ready), MAT_W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors with the output always drained.
    for (int v = 0; v < 5; v++) begin
      n = int'(vecs[v].size) + 2;
      do_load(vecs[v].size, vecs[v].din, n * n, vecs[v].gaps, 1'b0, 1'b1);
      chk_done($sformatf("vec%0d", v), vecs[v].size, vecs[v].exp_mat);
      @(negedge clk);
      chk($sformatf("vec%0d_drained", v), MAT_W'(bus.out_valid), MAT_W'(0));
    end

    // start / matrix_size changes during LOAD are ignored.
    do_load(2'b01, vecs[0].din, 9, 1'b0, 1'b1, 1'b1);
    chk_done("inject", 2'b01, exp_v1);
    @(negedge clk);
    chk("inject_drained", MAT_W'(bus.out_valid), MAT_W'(0));

    // Backpressure: A waits in the slot, B parks in PEND.
    bus.out_ready = 1'b0;
    d = 200'h04030201;
    exp_a = 200'h0403_000000_0201;
    do_load(2'b00, d, 4, 1'b0, 1'b0, 1'b1);
    chk_done("bp_a", 2'b00, exp_a);
    d = 200'h08070605;
    exp_b = 200'h0807_000000_0605;
    do_load(2'b00, d, 4, 1'b0, 1'b0, 1'b0);
    chk("pend_busy", MAT_W'(bus.busy), MAT_W'(1));
    chk("pend_in_ready", MAT_W'(bus.in_ready), MAT_W'(0));
    chk("pend_matrix_a", bus.matrix_out, exp_a);
    chk("pend_out_valid", MAT_W'(bus.out_valid), MAT_W'(1));
    @(negedge clk);
    chk("pend_hold_matrix_a", bus.matrix_out, exp_a);
    chk("pend_hold_busy", MAT_W'(bus.busy), MAT_W'(1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("pend_exit_matrix_b", bus.matrix_out, exp_b);
    chk("pend_exit_out_valid", MAT_W'(bus.out_valid), MAT_W'(1));
    chk("pend_exit_busy", MAT_W'(bus.busy), MAT_W'(0));
    @(negedge clk);
    chk("pend_b_drained", MAT_W'(bus.out_valid), MAT_W'(0));

    // Asynchronous reset mid-load with a held output.
    bus.out_ready = 1'b0;
    do_load(2'b01, vecs[0].din, 9, 1'b0, 1'b0, 1'b1);
    chk_done("pre_rst", 2'b01, exp_v1);
    d = '1;
    do_load(2'b01, d, 4, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", MAT_W'(bus.out_valid), MAT_W'(0));
    chk("async_rst_matrix_out", bus.matrix_out, '0);
    chk("async_rst_size_out", MAT_W'(bus.size_out), MAT_W'(0));
    chk("async_rst_busy", MAT_W'(bus.busy), MAT_W'(0));
    chk("async_rst_in_ready", MAT_W'(bus.in_ready), MAT_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    do_load(2'b01, vecs[0].din, 9, 1'b0, 1'b0, 1'b1);
    chk_done("post_rst", 2'b01, exp_v1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
